// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and a small window-decode helper.
// No latency: constants and a pure function only.
// No flow control: consumed at elaboration time or as combinational logic.
package vga_timing_pkg;

  // Default timing for 640x480@60 from a 100 MHz system clock.
  localparam int CLK_DIV_DEF   = 4;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  // Line and frame totals; the renderers share these.
  // Counters are 10 bits wide, so both totals must stay at or below 1024.
  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int CNT_W       = 10;

  // True when lo <= cnt < lo+len. The compare is done in int so that a window
  // ending exactly at 1024 does not wrap.
  function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int lo, input int len);
    return (int'(cnt) >= lo) && (int'(cnt) < lo + len);
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate divider: pix_tick is high on the last clk of every CLK_DIV-clk pixel period.
// pix_tick is decoded from the divider register; the first tick is CLK_DIV-1 clks after reset release.
// No flow control: the divider free-runs.
module vga_pixel_tick
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF  // must be >= 2 so that pix_tick is low during reset
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  // Divider counts 0..CLK_DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign pix_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: pixel counters, sync decode, and the registered colour/sync output stage.
// Counters advance on pix_tick; colour and sync for a pixel leave one clk after its tick, with no skew between them.
// No flow control: the renderer must settle rgb_in combinationally within CLK_DIV-1 clks of the counters changing.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      rgb_in,
  output logic [CNT_W-1:0] x_cnt,
  output logic [CNT_W-1:0] y_cnt,
  output logic             pix_tick,
  output logic             active,
  output logic             vblank,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic [3:0]       vgaRed,
  output logic [3:0]       vgaGreen,
  output logic [3:0]       vgaBlue
);

  localparam int               H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int               V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(V_TOTAL - 1);

  logic        hsync_next;
  logic        vsync_next;
  logic [11:0] rgb_q;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick)
  );

  // Raster counters: x wraps at the end of a line and carries into y; both wrap together at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (pix_tick) begin
      if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        if (y_cnt == Y_LAST) begin
          y_cnt <= '0;
        end else begin
          y_cnt <= y_cnt + CNT_W'(1);
        end
      end else begin
        x_cnt <= x_cnt + CNT_W'(1);
      end
    end
  end

  assign active      = (int'(x_cnt) < H_VISIBLE) && (int'(y_cnt) < V_VISIBLE);
  assign vblank      = (int'(y_cnt) >= V_VISIBLE);
  assign frame_start = pix_tick && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
  assign hsync_next  = !in_window(x_cnt, H_VISIBLE + H_FRONT, H_SYNC);
  assign vsync_next  = !in_window(y_cnt, V_VISIBLE + V_FRONT, V_SYNC);

  // Output stage: colour and sync are sampled from the same pre-increment counters so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb_q <= 12'h000;
    end else if (pix_tick) begin
      hsync <= hsync_next;
      vsync <= vsync_next;
      rgb_q <= active ? rgb_in : 12'h000;
    end
  end

  assign vgaRed   = rgb_q[11:8];
  assign vgaGreen = rgb_q[7:4];
  assign vgaBlue  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default-timing instance for reset, line timing, blank gating and alignment;
// a reduced-timing instance for frame-level behaviour (vsync, frame_start, vblank, mid-frame reset).
// Expected values are closed-form functions of the clk count since reset release.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d, rst_s;
  logic        align;
  logic [11:0] rgb_d, rgb_s;

  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_tick, d_act, d_vbl, d_fs, d_hs, d_vs;
  logic       s_tick, s_act, s_vbl, s_fs, s_hs, s_vs;
  logic [3:0] d_r, d_g, d_b, s_r, s_g, s_b;

  // Renderer stand-ins: solid white, or the current x coordinate once alignment mode is on.
  assign rgb_d = align ? {2'b00, d_x} : 12'hFFF;
  assign rgb_s = 12'hFFF;

  vga_timing dut_d (
    .clk(clk), .rst(rst_d), .rgb_in(rgb_d),
    .x_cnt(d_x), .y_cnt(d_y), .pix_tick(d_tick), .active(d_act), .vblank(d_vbl),
    .frame_start(d_fs), .hsync(d_hs), .vsync(d_vs),
    .vgaRed(d_r), .vgaGreen(d_g), .vgaBlue(d_b)
  );

  // Small raster: CLK_DIV=2, H_TOTAL=15 (sync 10..12), V_TOTAL=10 (sync 7..8), frame = 300 clks.
  vga_timing #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .clk(clk), .rst(rst_s), .rgb_in(rgb_s),
    .x_cnt(s_x), .y_cnt(s_y), .pix_tick(s_tick), .active(s_act), .vblank(s_vbl),
    .frame_start(s_fs), .hsync(s_hs), .vsync(s_vs),
    .vgaRed(s_r), .vgaGreen(s_g), .vgaBlue(s_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at clk %0d: observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  initial begin
    int t, q, qx, qy, x, y;
    int first_move, hs_low, fall1, fall2, vs_low, vs_first, fs1, fs2;
    logic prev_hs, prev_vs, exp_hs, exp_vs;
    logic [11:0] exp_col;

    // Reset state.
    rst_d = 1'b1;
    rst_s = 1'b1;
    align = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_x", 0, 32'(d_x), 0);
    chk("rst_y", 0, 32'(d_y), 0);
    chk("rst_hsync", 0, 32'(d_hs), 1);
    chk("rst_vsync", 0, 32'(d_vs), 1);
    chk("rst_colour", 0, 32'({d_r, d_g, d_b}), 0);
    chk("rst_tick", 0, 32'(d_tick), 0);
    chk("rst_frame_start", 0, 32'(d_fs), 0);
    rst_d = 1'b0;
    rst_s = 1'b0;

    // Default instance: two full lines plus a little. Line 0 with white input, line 1 with x as colour.
    first_move = -1; hs_low = 0; fall1 = -1; fall2 = -1; prev_hs = 1'b1;
    for (int e = 1; e <= 6600; e++) begin
      @(negedge clk);
      t = e / 4;
      x = t % 800;
      y = t / 800;
      chk("d_x", e, 32'(d_x), 32'(x));
      chk("d_y", e, 32'(d_y), 32'(y));
      chk("d_tick", e, 32'(d_tick), 32'(e % 4 == 3));
      chk("d_active", e, 32'(d_act), 32'(x < 640));
      chk("d_vblank", e, 32'(d_vbl), 0);
      chk("d_frame_start", e, 32'(d_fs), 0);
      chk("d_vsync", e, 32'(d_vs), 1);
      if (e < 4) begin
        exp_hs  = 1'b1;
        exp_col = 12'h000;
      end else begin
        q  = t - 1;
        qx = q % 800;
        exp_hs  = !(qx >= 656 && qx < 752);
        exp_col = (qx < 640) ? ((q >= 800) ? 12'(qx) : 12'hFFF) : 12'h000;
      end
      chk("d_hsync", e, 32'(d_hs), 32'(exp_hs));
      chk("d_colour", e, 32'({d_r, d_g, d_b}), 32'(exp_col));
      if (first_move < 0 && d_x != 10'd0) first_move = e;
      if (e <= 3200 && d_hs == 1'b0) hs_low++;
      if (prev_hs == 1'b1 && d_hs == 1'b0) begin
        if (fall1 < 0) fall1 = e;
        else if (fall2 < 0) fall2 = e;
      end
      prev_hs = d_hs;
      if (e == 3200) align = 1'b1;
    end
    chk("first_tick_clks", 0, 32'(first_move), 4);
    chk("hsync_low_clks", 0, 32'(hs_low), 384);
    chk("hsync_fall_clk", 0, 32'(fall1), 2628);
    chk("line_period_clks", 0, 32'(fall2 - fall1), 3200);

    // Small instance has free-run for 6600 clks = 22 frames; 100 more clks puts it at (x=5, y=3).
    repeat (100) @(negedge clk);
    chk("s_pre_rst_x", 6700, 32'(s_x), 5);
    chk("s_pre_rst_y", 6700, 32'(s_y), 3);

    // One-clk reset mid-frame.
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    chk("mid_rst_x", 0, 32'(s_x), 0);
    chk("mid_rst_y", 0, 32'(s_y), 0);
    chk("mid_rst_hsync", 0, 32'(s_hs), 1);
    chk("mid_rst_vsync", 0, 32'(s_vs), 1);
    chk("mid_rst_colour", 0, 32'({s_r, s_g, s_b}), 0);
    chk("mid_rst_tick", 0, 32'(s_tick), 0);

    // Small instance after restart: a little over two frames.
    vs_low = 0; vs_first = -1; fs1 = -1; fs2 = -1; prev_vs = 1'b1;
    for (int e = 1; e <= 650; e++) begin
      @(negedge clk);
      t = e / 2;
      x = t % 15;
      y = (t / 15) % 10;
      chk("s_x", e, 32'(s_x), 32'(x));
      chk("s_y", e, 32'(s_y), 32'(y));
      chk("s_tick", e, 32'(s_tick), 32'(e % 2 == 1));
      chk("s_active", e, 32'(s_act), 32'(x < 8 && y < 6));
      chk("s_vblank", e, 32'(s_vbl), 32'(y >= 6));
      chk("s_frame_start", e, 32'(s_fs), 32'((e % 2 == 1) && (t % 150 == 149)));
      if (e < 2) begin
        exp_hs  = 1'b1;
        exp_vs  = 1'b1;
        exp_col = 12'h000;
      end else begin
        q  = (t - 1) % 150;
        qx = q % 15;
        qy = q / 15;
        exp_hs  = !(qx >= 10 && qx < 13);
        exp_vs  = !(qy >= 7 && qy < 9);
        exp_col = (qx < 8 && qy < 6) ? 12'hFFF : 12'h000;
      end
      chk("s_hsync", e, 32'(s_hs), 32'(exp_hs));
      chk("s_vsync", e, 32'(s_vs), 32'(exp_vs));
      chk("s_colour", e, 32'({s_r, s_g, s_b}), 32'(exp_col));
      if (e <= 300 && s_vs == 1'b0) vs_low++;
      if (vs_first < 0 && prev_vs == 1'b1 && s_vs == 1'b0) vs_first = e;
      prev_vs = s_vs;
      if (s_fs) begin
        if (fs1 < 0) fs1 = e;
        else if (fs2 < 0) fs2 = e;
      end
    end
    chk("vsync_low_clks", 0, 32'(vs_low), 60);
    chk("vsync_fall_clk", 0, 32'(vs_first), 212);
    chk("frame_start_first", 0, 32'(fs1), 299);
    chk("frame_period_clks", 0, 32'(fs2 - fs1), 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
